// File: rtl/inst_rom_loader.sv
// Instruction ROM filled by a serial byte-stream boot loader with an XOR checksum.
// Keeps the core in reset until a load completes and serves words combinationally.
module inst_rom_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_data_i,
  output logic                  ld_ready_o,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic                  load_err_o,
  output logic [DEPTH_LOG2:0]   word_cnt_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state,      w_state_nx;
  logic [15:0]           r_n,          w_n_nx;
  logic [DEPTH_LOG2:0]   r_wr_ptr,     w_wr_ptr_nx;
  logic [1:0]            r_byte_idx,   w_byte_idx_nx;
  logic [7:0]            r_csum,       w_csum_nx;
  logic [23:0]           r_shift,      w_shift_nx;
  logic                  r_cpu_rst;
  logic                  w_accept;
  logic                  w_we;
  logic [31:0]           w_wdata;
  logic [15:0]           w_n_full;
  logic [DEPTH_LOG2:0]   w_wr_ptr_inc;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_unused_addr_bits;

  logic [31:0] r_mem [DEPTH];

  assign ld_ready_o   = !rst && (r_state == S_HDR0 || r_state == S_HDR1 ||
                                 r_state == S_DATA || r_state == S_CSUM);
  assign w_accept     = ld_valid_i && ld_ready_o;
  assign w_n_full     = {r_n[15:8], ld_data_i};
  assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
  assign w_wdata      = {r_shift, ld_data_i};

  always_comb begin
    w_state_nx    = r_state;
    w_n_nx        = r_n;
    w_wr_ptr_nx   = r_wr_ptr;
    w_byte_idx_nx = r_byte_idx;
    w_csum_nx     = r_csum;
    w_shift_nx    = r_shift;
    w_we          = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_HDR0: begin
          w_n_nx     = {ld_data_i, 8'h00};
          w_state_nx = S_HDR1;
        end
        S_HDR1: begin
          w_n_nx = w_n_full;
          if (32'(w_n_full) > DEPTH)   w_state_nx = S_ERR;
          else if (w_n_full == 16'h0)  w_state_nx = S_CSUM;
          else                         w_state_nx = S_DATA;
        end
        S_DATA: begin
          w_csum_nx  = r_csum ^ ld_data_i;
          w_shift_nx = {r_shift[15:0], ld_data_i};
          if (r_byte_idx == 2'd3) begin
            w_we          = 1'b1;
            w_wr_ptr_nx   = w_wr_ptr_inc;
            w_byte_idx_nx = 2'd0;
            if (32'(w_wr_ptr_inc) == 32'(r_n)) w_state_nx = S_CSUM;
          end else begin
            w_byte_idx_nx = r_byte_idx + 2'd1;
          end
        end
        S_CSUM: w_state_nx = (ld_data_i == r_csum) ? S_DONE : S_ERR;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HDR0;
      r_n        <= '0;
      r_wr_ptr   <= '0;
      r_byte_idx <= '0;
      r_csum     <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_n        <= w_n_nx;
      r_wr_ptr   <= w_wr_ptr_nx;
      r_byte_idx <= w_byte_idx_nx;
      r_csum     <= w_csum_nx;
      r_shift    <= w_shift_nx;
    end
  end

  // Core reset lags DONE by one cycle so the core sees a fully settled ROM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cpu_rst <= 1'b1;
    else     r_cpu_rst <= (r_state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_wdata;
  end

  // Words at or beyond wr_ptr read as NOP, so the array itself needs no reset.
  assign w_rd_idx   = rom_addr_i[DEPTH_LOG2+1:2];
  assign rom_data_o = (rom_ce_i && ({1'b0, w_rd_idx} < r_wr_ptr)) ? r_mem[w_rd_idx] : '0;
  assign w_unused_addr_bits = ^{rom_addr_i[31:DEPTH_LOG2+2], rom_addr_i[1:0]};

  assign cpu_rst_o   = r_cpu_rst;
  assign load_done_o = (r_state == S_DONE);
  assign load_err_o  = (r_state == S_ERR);
  assign word_cnt_o  = r_wr_ptr;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: good/bad/oversize/empty loads and mid-load reset.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid_i = 1'b0;
  logic [7:0]  ld_data_i = '0;
  logic        ld_ready_o;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = '0;
  logic [31:0] rom_data_o;
  logic        cpu_rst_o;
  logic        load_done_o;
  logic        load_err_o;
  logic [10:0] word_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  inst_rom_loader #(.DEPTH_LOG2(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .cpu_rst_o   (cpu_rst_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        ce;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rd_vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    ld_valid_i = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    ld_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 32'(ld_ready_o), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_wcnt", 32'(word_cnt_o), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read(input string name, input logic [31:0] a, input logic [31:0] exp);
    rom_ce_i   = 1'b1;
    rom_addr_i = a;
    #1;
    check(name, rom_data_o, exp);
  endtask

  initial begin
    rd_vecs[0] = '{32'h0000_0000, 1'b1, 32'h2401_0001};
    rd_vecs[1] = '{32'h0000_0004, 1'b1, 32'h3402_FFFF};
    rd_vecs[2] = '{32'h0000_0008, 1'b1, 32'h0000_0000};
    rd_vecs[3] = '{32'h0000_1000, 1'b1, 32'h2401_0001};
    rd_vecs[4] = '{32'h0000_0007, 1'b1, 32'h3402_FFFF};
    rd_vecs[5] = '{32'hFFFF_1004, 1'b1, 32'h3402_FFFF};
    rd_vecs[6] = '{32'h0000_0000, 1'b0, 32'h0000_0000};

    // Reset state
    rst = 1'b1;
    rom_ce_i = 1'b1;
    rom_addr_i = '0;
    @(posedge clk); #1;
    check("reset_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("reset_ready", 32'(ld_ready_o), 32'd0);
    check("reset_done", 32'(load_done_o), 32'd0);
    check("reset_err", 32'(load_err_o), 32'd0);
    check("reset_wcnt", 32'(word_cnt_o), 32'd0);
    check("reset_rdata", rom_data_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(ld_ready_o), 32'd1);

    // Good load, back-to-back
    send(8'h00); send(8'h02);
    send(8'h24); send(8'h01); send(8'h00);
    check("good_wcnt_before", 32'(word_cnt_o), 32'd0);
    send(8'h01);
    check("good_wcnt1", 32'(word_cnt_o), 32'd1);
    read("good_word0_early", 32'h0, 32'h2401_0001);
    read("good_word1_unloaded", 32'h4, 32'h0);
    send(8'h34); send(8'h02); send(8'hFF); send(8'hFF);
    check("good_wcnt2", 32'(word_cnt_o), 32'd2);
    check("good_not_done_yet", 32'(load_done_o), 32'd0);
    send(8'h12);
    ld_valid_i = 1'b0;
    check("good_done", 32'(load_done_o), 32'd1);
    check("good_cpu_rst_lag", 32'(cpu_rst_o), 32'd1);
    check("good_ready_off", 32'(ld_ready_o), 32'd0);
    @(posedge clk); #1;
    check("good_cpu_rst_rel", 32'(cpu_rst_o), 32'd0);
    for (int i = 0; i < 7; i++) begin
      rom_ce_i   = rd_vecs[i].ce;
      rom_addr_i = rd_vecs[i].addr;
      #1;
      check($sformatf("rd_vec%0d", i), rom_data_o, rd_vecs[i].exp);
    end
    send(8'h55);
    idle(1);
    check("done_ignores_bytes", 32'(word_cnt_o), 32'd2);
    check("done_stays", 32'(load_done_o), 32'd1);

    // Bad checksum
    do_reset();
    send(8'h00); send(8'h02);
    send(8'h24); send(8'h01); send(8'h00); send(8'h01);
    send(8'h34); send(8'h02); send(8'hFF); send(8'hFF);
    send(8'h13);
    ld_valid_i = 1'b0;
    check("bad_err", 32'(load_err_o), 32'd1);
    check("bad_done", 32'(load_done_o), 32'd0);
    check("bad_ready", 32'(ld_ready_o), 32'd0);
    check("bad_wcnt", 32'(word_cnt_o), 32'd2);
    send(8'h12); send(8'h00);
    idle(2);
    check("bad_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("bad_err_sticky", 32'(load_err_o), 32'd1);
    check("bad_wcnt_hold", 32'(word_cnt_o), 32'd2);

    // Oversize header: 0x0401 > 1024
    do_reset();
    send(8'h04);
    check("over_hdr1_noerr", 32'(load_err_o), 32'd0);
    send(8'h01);
    ld_valid_i = 1'b0;
    check("over_err", 32'(load_err_o), 32'd1);
    check("over_ready", 32'(ld_ready_o), 32'd0);
    check("over_wcnt", 32'(word_cnt_o), 32'd0);

    // Exactly full size is legal
    do_reset();
    send(8'h04); send(8'h00);
    ld_valid_i = 1'b0;
    check("full_noerr", 32'(load_err_o), 32'd0);
    check("full_ready", 32'(ld_ready_o), 32'd1);

    // Empty program with gaps
    do_reset();
    send(8'h00); idle(3);
    send(8'h00); idle(3);
    check("empty_ready_csum", 32'(ld_ready_o), 32'd1);
    check("empty_not_done", 32'(load_done_o), 32'd0);
    send(8'h00);
    ld_valid_i = 1'b0;
    check("empty_done", 32'(load_done_o), 32'd1);
    @(posedge clk); #1;
    check("empty_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check("empty_wcnt", 32'(word_cnt_o), 32'd0);
    read("empty_rd0", 32'h0, 32'h0);
    read("empty_rd4", 32'h4, 32'h0);

    // Mid-load reset, then a fresh load
    do_reset();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC);
    do_reset();
    check("mid_ready_hdr0", 32'(ld_ready_o), 32'd1);
    check("mid_cpu_rst", 32'(cpu_rst_o), 32'd1);
    send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("mid_wcnt1", 32'(word_cnt_o), 32'd1);
    send(8'h44);
    ld_valid_i = 1'b0;
    check("mid_done", 32'(load_done_o), 32'd1);
    read("mid_rd0", 32'h0, 32'h1122_3344);
    read("mid_rd4", 32'h4, 32'h0);
    @(posedge clk); #1;
    check("mid_cpu_rst_rel", 32'(cpu_rst_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
